// File: rtl/core_boot_harness.sv
// core_boot_harness: bring-up controller for the single-cycle RISC-V core.
// Streams a program into instruction memory over a valid/ready port, holds the
// core in reset until the last word has landed, then runs the core under a
// cycle watchdog and reports pass / fail / timeout.
// Optional macro RETIRE_COUNT_EN adds the instret retired-instruction counter.
module core_boot_harness #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned MAX_CYCLES  = 1000,
  parameter logic [31:0] TOHOST_ADDR = 32'h0000_0FF0,
  parameter logic [31:0] HALT_INSTR  = 32'h0010_0073,
  parameter int unsigned CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              ld_valid,
  input  logic [31:0]       ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst,
  input  logic              ex_valid,
  input  logic [31:0]       ex_instr,
  input  logic              dmem_we,
  input  logic [31:0]       dmem_addr,
  input  logic [31:0]       dmem_wdata,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [31:0]       result,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [ADDR_W:0]   words_loaded
`ifdef RETIRE_COUNT_EN
  , output logic [CNT_W-1:0] instret
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RELEASE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic hs;
  logic mem_full;
  logic start_ok;
  logic hit_tohost;
  logic hit_halt;
  logic hit_limit;

  // The handshake that fills the last free word also closes the load.
  assign hs         = (state == S_LOAD) && ld_valid;
  assign mem_full   = &words_loaded[ADDR_W-1:0];
  assign start_ok   = start && ((state == S_IDLE) || (state == S_DONE));
  assign hit_tohost = dmem_we && (dmem_addr == TOHOST_ADDR);
  assign hit_halt   = ex_valid && (ex_instr == HALT_INSTR);
  assign hit_limit  = (cycle_count == CNT_W'(MAX_CYCLES - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state decode plus the state-derived handshake and core reset.
  always_comb begin
    state_nx = state;
    ld_ready = 1'b0;
    core_rst = 1'b1;
    case (state)
      S_IDLE:    if (start) state_nx = S_LOAD;
      S_LOAD: begin
        ld_ready = 1'b1;
        if (ld_valid && (ld_last || mem_full)) state_nx = S_RELEASE;
      end
      S_RELEASE: state_nx = S_RUN;
      S_RUN: begin
        core_rst = 1'b0;
        if (hit_tohost || hit_halt || hit_limit) state_nx = S_DONE;
      end
      S_DONE:    if (start) state_nx = S_LOAD;
      default:   state_nx = S_IDLE;
    endcase
  end

  // Load datapath, run counters and sticky result flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      imem_we      <= 1'b0;
      imem_waddr   <= '0;
      imem_wdata   <= '0;
      done         <= 1'b0;
      pass         <= 1'b0;
      timeout      <= 1'b0;
      result       <= '0;
      cycle_count  <= '0;
      words_loaded <= '0;
    end else begin
      imem_we <= 1'b0;
      if (start_ok) begin
        done         <= 1'b0;
        pass         <= 1'b0;
        timeout      <= 1'b0;
        result       <= '0;
        cycle_count  <= '0;
        words_loaded <= '0;
        imem_waddr   <= '0;
      end
      if (hs) begin
        imem_we      <= 1'b1;
        imem_waddr   <= words_loaded[ADDR_W-1:0];
        imem_wdata   <= ld_data;
        words_loaded <= words_loaded + 1'b1;
      end
      // The terminating cycle does not advance cycle_count, so a timeout
      // reports MAX_CYCLES-1 after exactly MAX_CYCLES run cycles.
      if (state == S_RUN) begin
        if (hit_tohost) begin
          done    <= 1'b1;
          result  <= dmem_wdata;
          pass    <= (dmem_wdata == 32'd1);
          timeout <= 1'b0;
        end else if (hit_halt) begin
          done    <= 1'b1;
          result  <= '0;
          pass    <= 1'b1;
          timeout <= 1'b0;
        end else if (hit_limit) begin
          done    <= 1'b1;
          result  <= '0;
          pass    <= 1'b0;
          timeout <= 1'b1;
        end else if (cycle_count != '1) begin
          cycle_count <= cycle_count + 1'b1;
        end
      end
    end
  end

`ifdef RETIRE_COUNT_EN
  // Retired-instruction counter; counts the halting instruction too.
  always_ff @(posedge clk) begin
    if (rst || start_ok)                                     instret <= '0;
    else if ((state == S_RUN) && ex_valid && (instret != '1)) instret <= instret + 1'b1;
  end
`endif

endmodule

// File: tb/tb_core_boot_harness.sv
// Directed bench for core_boot_harness: one full-size instance (watchdog of
// 20 cycles) and one tiny-memory instance (ADDR_W=2) for the fill boundary.
module tb_core_boot_harness;

  localparam logic [31:0] TOHOST = 32'h0000_0FF0;
  localparam logic [31:0] HALT   = 32'h0010_0073;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A stimulus/observation
  logic        a_start = 0, a_ld_valid = 0, a_ld_last = 0;
  logic [31:0] a_ld_data = '0;
  logic        a_ex_valid = 0, a_dmem_we = 0;
  logic [31:0] a_ex_instr = '0, a_dmem_addr = '0, a_dmem_wdata = '0;
  logic        a_ld_ready, a_imem_we, a_core_rst, a_done, a_pass, a_timeout;
  logic [9:0]  a_imem_waddr;
  logic [31:0] a_imem_wdata, a_result, a_cycle_count;
  logic [10:0] a_words_loaded;

  // Instance B stimulus/observation
  logic        b_start = 0, b_ld_valid = 0, b_ld_last = 0;
  logic [31:0] b_ld_data = '0;
  logic        b_ld_ready, b_imem_we, b_core_rst, b_done, b_pass, b_timeout;
  logic [1:0]  b_imem_waddr;
  logic [31:0] b_imem_wdata, b_result, b_cycle_count;
  logic [2:0]  b_words_loaded;

`ifdef RETIRE_COUNT_EN
  logic [31:0] a_instret, b_instret;
`endif

  core_boot_harness #(.ADDR_W(10), .MAX_CYCLES(20)) u_a (
    .clk(clk), .rst(rst), .start(a_start),
    .ld_valid(a_ld_valid), .ld_data(a_ld_data), .ld_last(a_ld_last), .ld_ready(a_ld_ready),
    .imem_we(a_imem_we), .imem_waddr(a_imem_waddr), .imem_wdata(a_imem_wdata),
    .core_rst(a_core_rst), .ex_valid(a_ex_valid), .ex_instr(a_ex_instr),
    .dmem_we(a_dmem_we), .dmem_addr(a_dmem_addr), .dmem_wdata(a_dmem_wdata),
    .done(a_done), .pass(a_pass), .timeout(a_timeout), .result(a_result),
    .cycle_count(a_cycle_count), .words_loaded(a_words_loaded)
`ifdef RETIRE_COUNT_EN
    , .instret(a_instret)
`endif
  );

  core_boot_harness #(.ADDR_W(2), .MAX_CYCLES(1000)) u_b (
    .clk(clk), .rst(rst), .start(b_start),
    .ld_valid(b_ld_valid), .ld_data(b_ld_data), .ld_last(b_ld_last), .ld_ready(b_ld_ready),
    .imem_we(b_imem_we), .imem_waddr(b_imem_waddr), .imem_wdata(b_imem_wdata),
    .core_rst(b_core_rst), .ex_valid(1'b0), .ex_instr(32'h0),
    .dmem_we(1'b0), .dmem_addr(32'h0), .dmem_wdata(32'h0),
    .done(b_done), .pass(b_pass), .timeout(b_timeout), .result(b_result),
    .cycle_count(b_cycle_count), .words_loaded(b_words_loaded)
`ifdef RETIRE_COUNT_EN
    , .instret(b_instret)
`endif
  );

  int n_total = 0;
  int n_pass  = 0;
  logic [31:0] prog [5] = '{32'h00500093, 32'h00700113, 32'h002081b3,
                            32'h00302023, 32'h00002203};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Restart instance A from IDLE/DONE with a one-word program; returns in RUN, count 0.
  task automatic a_restart_one(input logic [31:0] w);
    a_start = 1; tick(); a_start = 0;
    a_ld_valid = 1; a_ld_data = w; a_ld_last = 1; tick();
    a_ld_valid = 0; a_ld_last = 0; tick();
  endtask

  initial begin
    // Reset
    tick(); tick();
    chk("rst_ld_ready", a_ld_ready, 0);
    chk("rst_imem_we", a_imem_we, 0);
    chk("rst_core_rst", a_core_rst, 1);
    chk("rst_done", a_done, 0);
    chk("rst_result", a_result, 0);
    chk("rst_cycle_count", a_cycle_count, 0);
    chk("rst_words_loaded", a_words_loaded, 0);
    rst = 0;
    tick();

    // Five-word load, ld_valid held high
    a_start = 1; tick(); a_start = 0;
    chk("load_ld_ready", a_ld_ready, 1);
    chk("load_core_rst", a_core_rst, 1);
    a_ld_valid = 1;
    for (int i = 0; i < 5; i++) begin
      a_ld_data = prog[i];
      a_ld_last = (i == 4);
      tick();
      chk($sformatf("load_we_%0d", i), a_imem_we, 1);
      chk($sformatf("load_waddr_%0d", i), a_imem_waddr, i);
      chk($sformatf("load_wdata_%0d", i), a_imem_wdata, prog[i]);
      chk($sformatf("load_words_%0d", i), a_words_loaded, i + 1);
    end
    a_ld_valid = 0; a_ld_last = 0;
    chk("release_ld_ready", a_ld_ready, 0);
    chk("release_core_rst", a_core_rst, 1);
    tick();
    chk("run_core_rst", a_core_rst, 0);
    chk("run_imem_we", a_imem_we, 0);
    chk("run_count0", a_cycle_count, 0);

    // Store 12 to tohost at run cycle 7
    for (int i = 0; i < 7; i++) tick();
    chk("run_count7", a_cycle_count, 7);
    chk("run_not_done", a_done, 0);
    a_dmem_we = 1; a_dmem_addr = TOHOST; a_dmem_wdata = 32'd12;
    tick();
    a_dmem_we = 0;
    chk("st12_done", a_done, 1);
    chk("st12_result", a_result, 12);
    chk("st12_pass", a_pass, 0);
    chk("st12_timeout", a_timeout, 0);
    chk("st12_count", a_cycle_count, 7);
    chk("st12_core_rst", a_core_rst, 1);
    a_ex_valid = 1; a_ex_instr = HALT; tick(); tick();
    a_ex_valid = 0;
    chk("done_frozen_count", a_cycle_count, 7);
    chk("done_frozen_result", a_result, 12);

    // Restart: tohost store of 1 and halt on the same cycle
    a_start = 1; tick(); a_start = 0;
    chk("restart_done_clr", a_done, 0);
    chk("restart_result_clr", a_result, 0);
    chk("restart_words_clr", a_words_loaded, 0);
    chk("restart_count_clr", a_cycle_count, 0);
    a_ld_valid = 1; a_ld_data = prog[0]; a_ld_last = 1; tick();
    a_ld_valid = 0; a_ld_last = 0;
    chk("restart_waddr", a_imem_waddr, 0);
    tick();
    a_dmem_we = 1; a_dmem_addr = TOHOST; a_dmem_wdata = 32'd1;
    a_ex_valid = 1; a_ex_instr = HALT;
    tick();
    a_dmem_we = 0; a_ex_valid = 0;
    chk("prio_done", a_done, 1);
    chk("prio_result", a_result, 1);
    chk("prio_pass", a_pass, 1);
    chk("prio_timeout", a_timeout, 0);

    // Halt after unrelated store and non-halt instruction
    a_restart_one(prog[1]);
    a_dmem_we = 1; a_dmem_addr = TOHOST + 32'd4; a_dmem_wdata = 32'd1;
    a_ex_valid = 1; a_ex_instr = prog[0];
    tick();
    a_dmem_we = 0; a_ex_valid = 0;
    chk("halt_not_done", a_done, 0);
    tick();
    a_ex_valid = 1; a_ex_instr = HALT;
    tick();
    a_ex_valid = 0;
    chk("halt_done", a_done, 1);
    chk("halt_pass", a_pass, 1);
    chk("halt_result", a_result, 0);
    chk("halt_count", a_cycle_count, 2);
`ifdef RETIRE_COUNT_EN
    chk("halt_instret", a_instret, 2);
`endif

    // Watchdog: MAX_CYCLES=20
    a_restart_one(prog[2]);
    for (int i = 0; i < 19; i++) tick();
    chk("to_not_yet", a_done, 0);
    chk("to_count19_pre", a_cycle_count, 19);
    tick();
    chk("to_done", a_done, 1);
    chk("to_timeout", a_timeout, 1);
    chk("to_pass", a_pass, 0);
    chk("to_count", a_cycle_count, 19);

    // Reset mid-load after two words, with a stall between them
    a_start = 1; tick(); a_start = 0;
    a_ld_valid = 1; a_ld_data = prog[0]; tick();
    a_ld_valid = 0; tick();
    chk("stall_we", a_imem_we, 0);
    chk("stall_words", a_words_loaded, 1);
    a_ld_valid = 1; a_ld_data = prog[1]; tick();
    a_ld_valid = 0;
    chk("mid_words2", a_words_loaded, 2);
    rst = 1; tick(); rst = 0;
    chk("midrst_words", a_words_loaded, 0);
    chk("midrst_core_rst", a_core_rst, 1);
    chk("midrst_ld_ready", a_ld_ready, 0);
    tick();
    chk("midrst_idle_ld_ready", a_ld_ready, 0);
    a_start = 1; tick(); a_start = 0;
    a_ld_valid = 1; a_ld_data = prog[3]; tick();
    a_ld_valid = 0;
    chk("reload_waddr", a_imem_waddr, 0);
    chk("reload_wdata", a_imem_wdata, prog[3]);
    chk("reload_words", a_words_loaded, 1);

    // Instance B: ADDR_W=2 fills after four words without ld_last
    b_start = 1; tick(); b_start = 0;
    b_ld_valid = 1;
    for (int i = 0; i < 4; i++) begin
      b_ld_data = prog[i];
      tick();
      chk($sformatf("fill_we_%0d", i), b_imem_we, 1);
      chk($sformatf("fill_waddr_%0d", i), b_imem_waddr, i);
    end
    chk("fill_ld_ready", b_ld_ready, 0);
    chk("fill_words", b_words_loaded, 4);
    tick();
    chk("fill_no_5th", b_imem_we, 0);
    chk("fill_run", b_core_rst, 0);
    chk("fill_words_hold", b_words_loaded, 4);
    b_ld_valid = 0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
